// File: rtl/mealy_stream_arb.sv
// Two-requester round-robin arbiter that streams each word LSB-first through an external Mealy FSM and returns the captured outputs.
// Latency: response valid WIDTH+2 cycles after the accept cycle; accepts at most every WIDTH+3 cycles.
// Backpressure: requesters see ready only in IDLE; the response is held in DONE until rsp_ready. Optional rsp_ones via MEALY_STREAM_ARB_ONES_EN.
module mealy_stream_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
`ifdef MEALY_STREAM_ARB_ONES_EN
    output logic [$clog2(WIDTH+1)-1:0] rsp_ones,
`endif
    output logic             fsm_reset,
    output logic             fsm_x,
    input  logic             fsm_outp,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLR,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] result;
    logic             id_q;
    logic             last_id;
    logic             grant;
    logic             accept;
    logic             last_bit;

`ifdef MEALY_STREAM_ARB_ONES_EN
    logic [$clog2(WIDTH+1)-1:0] ones_cnt;
    assign rsp_ones = ones_cnt;
`endif

    // Tie goes to the requester not served last; a lone requester always wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_id;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign accept   = (state == ST_IDLE) && (grant ? req1_valid : req0_valid);
    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (accept) state_nxt = ST_CLR;
            ST_CLR:   state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_nxt = ST_DONE;
            ST_DONE:  if (rsp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are masked by reset because the state register only clears on the edge.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b0;
        fsm_x      = 1'b0;
        fsm_reset  = 1'b1;
        if (!reset) begin
            req0_ready = (state == ST_IDLE) && !grant;
            req1_ready = (state == ST_IDLE) && grant;
            rsp_valid  = (state == ST_DONE);
            busy       = (state != ST_IDLE);
            fsm_x      = (state == ST_SHIFT) && data_q[bit_cnt];
            fsm_reset  = (state == ST_CLR);
        end
    end

    assign rsp_data = result;
    assign rsp_id   = id_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            data_q   <= '0;
            result   <= '0;
            id_q     <= 1'b0;
            last_id  <= 1'b1;
`ifdef MEALY_STREAM_ARB_ONES_EN
            ones_cnt <= '0;
`endif
        end else begin
            state <= state_nxt;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        data_q  <= grant ? req1_data : req0_data;
                        id_q    <= grant;
                        last_id <= grant;
                    end
                end
                ST_CLR: begin
                    bit_cnt  <= '0;
`ifdef MEALY_STREAM_ARB_ONES_EN
                    ones_cnt <= '0;
`endif
                end
                ST_SHIFT: begin
                    result[bit_cnt] <= fsm_outp;
                    // Hold on the final bit so the counter never wraps.
                    if (!last_bit) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
`ifdef MEALY_STREAM_ARB_ONES_EN
                    ones_cnt <= ones_cnt + {{($clog2(WIDTH+1)-1){1'b0}}, fsm_outp};
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mealy_stream_arb.sv
// Directed bench for mealy_stream_arb with a rising-edge-detector Mealy FSM model (out = x & ~prev_x).
module tb_mealy_stream_arb;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_data, req1_data;
    logic         req0_ready, req1_ready;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_id;
    logic         fsm_reset, fsm_x, fsm_outp;
    logic         busy;
`ifdef MEALY_STREAM_ARB_ONES_EN
    logic [$clog2(W+1)-1:0] rsp_ones;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Mealy FSM: output 1 on a 0->1 transition of x, previous bit cleared by fsm_reset.
    logic m_prev;
    always_ff @(posedge clk) m_prev <= fsm_reset ? 1'b0 : fsm_x;
    assign fsm_outp = fsm_x & ~m_prev;

    mealy_stream_arb #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
`ifdef MEALY_STREAM_ARB_ONES_EN
        .rsp_ones   (rsp_ones),
`endif
        .fsm_reset  (fsm_reset),
        .fsm_x      (fsm_x),
        .fsm_outp   (fsm_outp),
        .busy       (busy)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ones(input string tag, input int exp);
`ifdef MEALY_STREAM_ARB_ONES_EN
        chk_eq(tag, 32'(rsp_ones), exp);
`endif
    endtask

    // One full transaction with rsp_ready high; cycle 0 is the accept cycle.
    task automatic do_txn(input logic id, input logic [W-1:0] dat, input logic [W-1:0] exp,
                          input int exp_ones, input string tag);
        logic found;
        found = 1'b0;
        if (id) begin req1_valid = 1'b1; req1_data = dat; end
        else    begin req0_valid = 1'b1; req0_data = dat; end
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) found = 1'b1;
            else next_cyc();
        end
        chk_eq({tag, "_accept"}, 32'(found), 1);
        next_cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!found) return;
        @(negedge clk);
        chk_eq({tag, "_rstpulse"}, 32'(fsm_reset), 1);
        chk_eq({tag, "_busy"}, 32'(busy), 1);
        chk_eq({tag, "_x_clr"}, 32'(fsm_x), 0);
        next_cyc();
        @(negedge clk);
        chk_eq({tag, "_rst_off"}, 32'(fsm_reset), 0);
        chk_eq({tag, "_x_bit0"}, 32'(fsm_x), 32'(dat[0]));
        repeat (7) next_cyc();
        @(negedge clk);
        chk_eq({tag, "_vld_c9"}, 32'(rsp_valid), 0);
        next_cyc();
        @(negedge clk);
        chk_eq({tag, "_vld_c10"}, 32'(rsp_valid), 1);
        chk_eq({tag, "_data"}, 32'(rsp_data), 32'(exp));
        chk_eq({tag, "_id"}, 32'(rsp_id), 32'(id));
        chk_ones({tag, "_ones"}, exp_ones);
        next_cyc();
        @(negedge clk);
        chk_eq({tag, "_idle"}, 32'(busy), 0);
        next_cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc_cyc[4];
        logic acc_id[4];
        int   n_acc;
        logic saw_vld;

        // Reset with both requesters already valid: outputs must stay gated.
        reset      = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = '0;
        req1_data  = '0;
        rsp_ready  = 1'b1;
        next_cyc();
        @(negedge clk);
        chk_eq("rst_rsp_valid", 32'(rsp_valid), 0);
        chk_eq("rst_req0_ready", 32'(req0_ready), 0);
        chk_eq("rst_req1_ready", 32'(req1_ready), 0);
        chk_eq("rst_busy", 32'(busy), 0);
        chk_eq("rst_fsm_x", 32'(fsm_x), 0);
        chk_eq("rst_fsm_reset", 32'(fsm_reset), 1);
        chk_eq("rst_rsp_data", 32'(rsp_data), 0);
        chk_eq("rst_rsp_id", 32'(rsp_id), 0);
        next_cyc();
        reset = 1'b0;

        // Round-robin with both requesters continuously valid.
        n_acc = 0;
        for (int c = 0; c < 60 && n_acc < 4; c++) begin
            @(negedge clk);
            chk_eq("rr_one_ready", 32'(req0_ready & req1_ready), 0);
            if (req0_ready || req1_ready) begin
                acc_cyc[n_acc] = c;
                acc_id[n_acc]  = req1_ready;
                n_acc++;
            end
            next_cyc();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk_eq("rr_count", 32'(n_acc), 4);
        if (n_acc == 4) begin
            chk_eq("rr_grant0", 32'(acc_id[0]), 0);
            chk_eq("rr_grant1", 32'(acc_id[1]), 1);
            chk_eq("rr_grant2", 32'(acc_id[2]), 0);
            chk_eq("rr_grant3", 32'(acc_id[3]), 1);
            chk_eq("rr_first_cyc", 32'(acc_cyc[0]), 0);
            chk_eq("rr_spacing", 32'(acc_cyc[3] - acc_cyc[2]), W + 3);
        end
        repeat (12) next_cyc();

        reset = 1'b1;
        next_cyc();
        reset = 1'b0;

        do_txn(1'b0, 8'h00, 8'h00, 0, "r0_00");
        do_txn(1'b1, 8'h01, 8'h01, 1, "r1_01");
        do_txn(1'b0, 8'h02, 8'h02, 1, "r0_02");
        do_txn(1'b0, 8'hFF, 8'h01, 1, "r0_ff");

        // Response backpressure with a pending request from requester 0.
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 8'h05;
        @(negedge clk);
        chk_eq("bp_accept", 32'(req0_ready), 1);
        repeat (10) next_cyc();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_eq("bp_hold_valid", 32'(rsp_valid), 1);
            chk_eq("bp_hold_data", 32'(rsp_data), 32'h05);
            chk_eq("bp_hold_busy", 32'(busy), 1);
            chk_eq("bp_no_accept", 32'(req0_ready), 0);
            next_cyc();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk_eq("bp_release_valid", 32'(rsp_valid), 1);
        chk_ones("bp_ones", 2);
        next_cyc();
        @(negedge clk);
        chk_eq("bp_idle_busy", 32'(busy), 0);
        chk_eq("bp_pending_ready", 32'(req0_ready), 1);
        req0_valid = 1'b0;
        next_cyc();

        // Reset pulsed while shifting bit 3 of 0xAA.
        req0_valid = 1'b1;
        req0_data  = 8'hAA;
        @(negedge clk);
        chk_eq("ab_accept", 32'(req0_ready), 1);
        next_cyc();
        req0_valid = 1'b0;
        repeat (4) next_cyc();
        @(negedge clk);
        chk_eq("ab_bit3_x", 32'(fsm_x), 1);
        reset = 1'b1;
        next_cyc();
        @(negedge clk);
        chk_eq("ab_rst_valid", 32'(rsp_valid), 0);
        chk_eq("ab_rst_fsm_reset", 32'(fsm_reset), 1);
        chk_eq("ab_rst_busy", 32'(busy), 0);
        reset = 1'b0;
        next_cyc();
        @(negedge clk);
        chk_eq("ab_idle_busy", 32'(busy), 0);
        chk_eq("ab_idle_fsm_reset", 32'(fsm_reset), 0);
        saw_vld = 1'b0;
        for (int k = 0; k < 12; k++) begin
            next_cyc();
            @(negedge clk);
            if (rsp_valid) saw_vld = 1'b1;
        end
        chk_eq("ab_no_response", 32'(saw_vld), 0);
        next_cyc();
        do_txn(1'b0, 8'h01, 8'h01, 1, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
